// File: rtl/tick_gen.sv
// tick_gen: multi-channel programmable tick / slow square-wave divider with a
// single-slot valid/ready config port. Optional pause input: TICK_GEN_PAUSE_EN.
module tick_gen #(
  parameter int                  NCH       = 4,
  parameter int                  CW        = 24,
  parameter logic [NCH*CW-1:0]   DIV_INIT  = {NCH{24'd833333}},
  parameter logic [NCH-1:0]      MODE_INIT = {NCH{1'b0}},
  localparam int                 CHW       = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   en,
  input  logic             sync_restart,
`ifdef TICK_GEN_PAUSE_EN
  input  logic             pause,
`endif
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CHW-1:0]   cfg_ch,
  input  logic [CW-1:0]    cfg_div,
  input  logic             cfg_mode,
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   clk_out
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_PEND = 1'b1} state_t;

  state_t          state_r, state_s;
  logic [CW-1:0]   cnt_r [NCH];
  logic [CW-1:0]   cnt_s [NCH];
  logic [CW-1:0]   div_r [NCH];
  logic [CW-1:0]   div_s [NCH];
  logic [NCH-1:0]  mode_r, mode_s;
  logic [NCH-1:0]  tick_r, tick_s;
  logic [NCH-1:0]  clk_out_r, clk_out_s;
  logic [CHW-1:0]  pend_ch_r, pend_ch_s;
  logic [CW-1:0]   pend_div_r, pend_div_s;
  logic            pend_mode_r, pend_mode_s;

  logic            pause_s;
  logic [NCH-1:0]  run_s, wrap_s, hit_s, load_s;
  logic            accept_s, direct_s, apply_s, pend_ok_s;
  logic [CW-1:0]   new_div_s;
  logic            new_mode_s;

`ifdef TICK_GEN_PAUSE_EN
  assign pause_s = pause;
`else
  assign pause_s = 1'b0;
`endif

  // A programmed divisor of zero behaves as one.
  function automatic logic [CW-1:0] eff_div(input logic [CW-1:0] d);
    return (d == {CW{1'b0}}) ? CW'(1'b1) : d;
  endfunction

  // Wrap detection and decode of which channel the config slot targets
  always_comb begin
    run_s      = {NCH{1'b0}};
    wrap_s     = {NCH{1'b0}};
    hit_s      = {NCH{1'b0}};
    load_s     = {NCH{1'b0}};
    accept_s   = cfg_valid && (state_r == ST_IDLE);
    direct_s   = accept_s && sync_restart;
    pend_ok_s  = (32'(pend_ch_r) < 32'(NCH));
    if (direct_s) begin
      new_div_s  = cfg_div;
      new_mode_s = cfg_mode;
    end else begin
      new_div_s  = pend_div_r;
      new_mode_s = pend_mode_r;
    end
    for (int i = 0; i < NCH; i++) begin
      run_s[i]  = en[i] && !pause_s;
      wrap_s[i] = run_s[i] && (cnt_r[i] >= (eff_div(div_r[i]) - CW'(1'b1)));
      hit_s[i]  = (state_r == ST_PEND) && (pend_ch_r == CHW'(i));
    end
    // Out-of-range targets match no channel and simply release the slot.
    apply_s = (state_r == ST_PEND) &&
              (sync_restart || !pend_ok_s || (|(hit_s & wrap_s)) || !(|(hit_s & run_s)));
    for (int i = 0; i < NCH; i++) begin
      load_s[i] = (apply_s && hit_s[i]) || (direct_s && (cfg_ch == CHW'(i)));
    end
  end

  // Config slot state transitions and pending capture
  always_comb begin
    state_s     = state_r;
    pend_ch_s   = pend_ch_r;
    pend_div_s  = pend_div_r;
    pend_mode_s = pend_mode_r;
    case (state_r)
      ST_IDLE: begin
        // A handshake coinciding with sync_restart is applied directly.
        if (accept_s && !sync_restart) begin
          state_s     = ST_PEND;
          pend_ch_s   = cfg_ch;
          pend_div_s  = cfg_div;
          pend_mode_s = cfg_mode;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_PEND: begin
        if (apply_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_PEND;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Per-channel counter, strobe and square-wave next state
  always_comb begin
    mode_s    = mode_r;
    tick_s    = {NCH{1'b0}};
    clk_out_s = clk_out_r;
    for (int i = 0; i < NCH; i++) begin
      cnt_s[i] = cnt_r[i];
      div_s[i] = div_r[i];
    end
    for (int i = 0; i < NCH; i++) begin
      if (load_s[i]) begin
        div_s[i]  = new_div_s;
        mode_s[i] = new_mode_s;
      end else begin
        div_s[i]  = div_r[i];
        mode_s[i] = mode_r[i];
      end
      if (sync_restart) begin
        cnt_s[i]     = {CW{1'b0}};
        tick_s[i]    = 1'b0;
        clk_out_s[i] = 1'b0;
      end else begin
        tick_s[i] = wrap_s[i];
        if (wrap_s[i] || load_s[i]) begin
          cnt_s[i] = {CW{1'b0}};
        end else if (run_s[i]) begin
          cnt_s[i] = cnt_r[i] + CW'(1'b1);
        end else begin
          cnt_s[i] = cnt_r[i];
        end
        if (load_s[i] && !mode_r[i] && new_mode_s) begin
          clk_out_s[i] = 1'b0;
        end else if (mode_r[i]) begin
          clk_out_s[i] = wrap_s[i];
        end else if (wrap_s[i]) begin
          clk_out_s[i] = ~clk_out_r[i];
        end else begin
          clk_out_s[i] = clk_out_r[i];
        end
      end
    end
  end

  // State registers with asynchronous reset to the programmed defaults
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      pend_ch_r   <= {CHW{1'b0}};
      pend_div_r  <= {CW{1'b0}};
      pend_mode_r <= 1'b0;
      mode_r      <= MODE_INIT;
      tick_r      <= {NCH{1'b0}};
      clk_out_r   <= {NCH{1'b0}};
      for (int i = 0; i < NCH; i++) begin
        cnt_r[i] <= {CW{1'b0}};
        div_r[i] <= DIV_INIT[i*CW +: CW];
      end
    end else begin
      state_r     <= state_s;
      pend_ch_r   <= pend_ch_s;
      pend_div_r  <= pend_div_s;
      pend_mode_r <= pend_mode_s;
      mode_r      <= mode_s;
      tick_r      <= tick_s;
      clk_out_r   <= clk_out_s;
      for (int i = 0; i < NCH; i++) begin
        cnt_r[i] <= cnt_s[i];
        div_r[i] <= div_s[i];
      end
    end
  end

  assign cfg_ready = (state_r == ST_IDLE);
  assign tick      = tick_r;
  assign clk_out   = clk_out_r;

endmodule

// File: tb/tb_tick_gen.sv
// tb_tick_gen: directed and randomized checks of tick_gen against a
// countdown-based reference model (cycles remaining until each channel's tick).
module tb_tick_gen;

  localparam int NCH = 6;
  localparam int CW  = 8;
  localparam int CHW = 3;
  localparam logic [NCH*CW-1:0] DIV_I  = {8'd6, 8'd2, 8'd7, 8'd4, 8'd3, 8'd5};
  localparam logic [NCH-1:0]    MODE_I = 6'b100000;

  logic            clk = 1'b0;
  logic            rst;
  logic [NCH-1:0]  en;
  logic            sync_restart;
  logic            cfg_valid;
  logic            cfg_ready;
  logic [CHW-1:0]  cfg_ch;
  logic [CW-1:0]   cfg_div;
  logic            cfg_mode;
  logic [NCH-1:0]  tick;
  logic [NCH-1:0]  clk_out;
`ifdef TICK_GEN_PAUSE_EN
  logic            pause;
`endif

  tick_gen #(.NCH(NCH), .CW(CW), .DIV_INIT(DIV_I), .MODE_INIT(MODE_I)) dut (
    .clk(clk), .rst(rst), .en(en), .sync_restart(sync_restart),
`ifdef TICK_GEN_PAUSE_EN
    .pause(pause),
`endif
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_div(cfg_div), .cfg_mode(cfg_mode), .tick(tick), .clk_out(clk_out)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: m_left = running cycles left until the wrap cycle (1 = wraps now).
  int              m_left [NCH];
  int              m_div  [NCH];
  bit [NCH-1:0]    m_mode, m_clk, m_tick;
  bit              m_ready;
  int              m_pch, m_pdiv;
  bit              m_pmode;
  logic [NCH*CW-1:0] div_init_v;

  function automatic int eff(input int d);
    return (d == 0) ? 1 : d;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    div_init_v = DIV_I;
    for (int i = 0; i < NCH; i++) begin
      m_div[i]  = int'(div_init_v[i*CW +: CW]);
      m_left[i] = eff(m_div[i]);
    end
    m_mode = MODE_I; m_clk = '0; m_tick = '0; m_ready = 1'b1;
    m_pch = 0; m_pdiv = 0; m_pmode = 1'b0;
  endtask

  task automatic model_step();
    bit run [NCH];
    bit pz, lmode, nready, w, oldm;
    int ld, ldiv;
    pz = 1'b0;
`ifdef TICK_GEN_PAUSE_EN
    pz = pause;
`endif
    ld = -1; ldiv = 0; lmode = 1'b0; nready = m_ready;
    for (int i = 0; i < NCH; i++) run[i] = en[i] && !pz;
    if (!m_ready) begin
      if (m_pch >= NCH) begin
        nready = 1'b1;
      end else if (sync_restart || !run[m_pch] || m_left[m_pch] == 1) begin
        nready = 1'b1; ld = m_pch; ldiv = m_pdiv; lmode = m_pmode;
      end
    end else if (cfg_valid) begin
      if (sync_restart) begin
        if (int'(cfg_ch) < NCH) begin
          ld = int'(cfg_ch); ldiv = int'(cfg_div); lmode = cfg_mode;
        end
      end else begin
        m_pch = int'(cfg_ch); m_pdiv = int'(cfg_div); m_pmode = cfg_mode; nready = 1'b0;
      end
    end
    for (int i = 0; i < NCH; i++) begin
      w    = run[i] && (m_left[i] == 1);
      oldm = m_mode[i];
      if (ld == i) begin
        m_div[i] = ldiv; m_mode[i] = lmode;
      end
      if (sync_restart) begin
        m_tick[i] = 1'b0; m_clk[i] = 1'b0; m_left[i] = eff(m_div[i]);
      end else begin
        m_tick[i] = w;
        if (ld == i || w) m_left[i] = eff(m_div[i]);
        else if (run[i]) m_left[i] = m_left[i] - 1;
        if (ld == i && !oldm && lmode) m_clk[i] = 1'b0;
        else if (oldm) m_clk[i] = w;
        else m_clk[i] = m_clk[i] ^ w;
      end
    end
    m_ready = nready;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("tick", 32'(tick), 32'(m_tick));
    check("clk_out", 32'(clk_out), 32'(m_clk));
    check("cfg_ready", 32'(cfg_ready), 32'(m_ready));
  endtask

  task automatic wait_tick(input int ch, output int n);
    n = 0;
    do begin
      cycle();
      n++;
    end while (!tick[ch] && n < 50);
  endtask

  task automatic send_cfg(input int ch, input int dv, input bit md);
    cfg_valid = 1'b1; cfg_ch = CHW'(ch); cfg_div = CW'(dv); cfg_mode = md;
    cycle();
    cfg_valid = 1'b0;
  endtask

  initial begin
    int nt, nc, no, n, n1, prev;
    int first [4];
    rst = 1'b1; en = '0; sync_restart = 1'b0; cfg_valid = 1'b0;
    cfg_ch = '0; cfg_div = '0; cfg_mode = 1'b0;
`ifdef TICK_GEN_PAUSE_EN
    pause = 1'b0;
`endif
    model_reset();
    #12 rst = 1'b0;
    check("rst_tick", 32'(tick), 32'd0);
    check("rst_clk_out", 32'(clk_out), 32'd0);
    check("rst_ready", 32'(cfg_ready), 32'd1);

    // ch0 alone at divisor 5, toggle mode
    en = 6'b000001; nt = 0; nc = 0; no = 0;
    for (int k = 0; k < 20; k++) begin
      cycle();
      nt += int'(tick[0]); nc += int'(clk_out[0]); no += int'(|tick[NCH-1:1]);
    end
    check("ch0_ticks_20", 32'(nt), 32'd4);
    check("ch0_clk_high_20", 32'(nc), 32'd10);
    check("others_quiet", 32'(no), 32'd0);

    // retune ch0 to 3 at cnt=1: current period stays 5
    cycle();
    send_cfg(0, 3, 1'b0);
    check("ready_drop", 32'(cfg_ready), 32'd0);
    wait_tick(0, n);
    check("rem_period", 32'(n + 2), 32'd5);
    check("ready_back", 32'(cfg_ready), 32'd1);
    wait_tick(0, n);
    check("new_period", 32'(n), 32'd3);

    // divisors 3,3,4,7 mid-period, then sync_restart
    en = 6'b001111;
    repeat (5) cycle();
    sync_restart = 1'b1; cycle(); sync_restart = 1'b0;
    check("sr_tick", 32'(tick), 32'd0);
    check("sr_clk_out", 32'(clk_out), 32'd0);
    for (int c = 0; c < 4; c++) first[c] = 0;
    for (int k = 1; k <= 8; k++) begin
      cycle();
      for (int c = 0; c < 4; c++) if (tick[c] && first[c] == 0) first[c] = k;
    end
    check("sr_first_ch0", 32'(first[0]), 32'd3);
    check("sr_first_ch1", 32'(first[1]), 32'd3);
    check("sr_first_ch2", 32'(first[2]), 32'd4);
    check("sr_first_ch3", 32'(first[3]), 32'd7);

    // divisor 0 to disabled ch1, then enable it
    en = 6'b001101;
    send_cfg(1, 0, 1'b0);
    check("div0_pend", 32'(cfg_ready), 32'd0);
    cycle();
    check("div0_applied", 32'(cfg_ready), 32'd1);
    en = 6'b001111;
    cycle();
    check("div0_first_tick", 32'(tick[1]), 32'd1);
    for (int k = 0; k < 6; k++) begin
      prev = int'(clk_out[1]);
      cycle();
      check("div0_tick_high", 32'(tick[1]), 32'd1);
      check("div0_clk_toggle", 32'(clk_out[1]), 32'(prev ^ 1));
    end

    // out-of-range channel is accepted and dropped
    send_cfg(7, 9, 1'b1);
    check("badch_pend", 32'(cfg_ready), 32'd0);
    cycle();
    check("badch_ready", 32'(cfg_ready), 32'd1);

    // randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      en           = NCH'($urandom);
      sync_restart = ($urandom_range(0, 31) == 0);
      cfg_valid    = ($urandom_range(0, 3) == 0);
      cfg_ch       = CHW'($urandom_range(0, 7));
      cfg_div      = CW'($urandom_range(0, 9));
      cfg_mode     = 1'($urandom);
`ifdef TICK_GEN_PAUSE_EN
      pause        = ($urandom_range(0, 7) == 0);
`endif
      cycle();
    end
    en = '0; sync_restart = 1'b0; cfg_valid = 1'b0;
`ifdef TICK_GEN_PAUSE_EN
    pause = 1'b0;
`endif
    repeat (2) cycle();

`ifdef TICK_GEN_PAUSE_EN
    // pause of 10 cycles delays ch2 (divisor 4) by exactly 10
    send_cfg(2, 4, 1'b0);
    cycle();
    en = 6'b000100;
    wait_tick(2, n);
    check("pause_pre_period", 32'(n), 32'd4);
    cycle(); cycle();
    pause = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cycle();
      check("pause_no_tick", 32'(tick), 32'd0);
    end
    pause = 1'b0;
    wait_tick(2, n1);
    check("pause_resume", 32'(n1 + 12), 32'd14);
`endif

    // asynchronous reset mid-period with a config pending
    en = 6'b111111;
    repeat (7) cycle();
    send_cfg(3, 9, 1'b1);
    #3 rst = 1'b1;
    #1;
    check("arst_tick", 32'(tick), 32'd0);
    check("arst_clk_out", 32'(clk_out), 32'd0);
    check("arst_ready", 32'(cfg_ready), 32'd1);
    model_reset();
    #2 rst = 1'b0;
    repeat (12) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
